// File: rtl/axi4_lite_fanout_n.sv
// One-to-NM AXI4-Lite fanout with per-direction outstanding tracking and an internal
// DECERR responder. Responses are only ever taken from the currently open target.
module axi4_lite_fanout_n #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned NM        = 4,
  parameter int unsigned SEL_LSB   = 12,
  parameter int unsigned MAX_OUT   = 4,
  parameter int unsigned DECERR_EN = 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  // upstream slave side
  input  logic [AW-1:0]        s_awaddr_i,
  input  logic                 s_awvalid_i,
  output logic                 s_awready_o,
  input  logic [DW-1:0]        s_wdata_i,
  input  logic [DW/8-1:0]      s_wstrb_i,
  input  logic                 s_wvalid_i,
  output logic                 s_wready_o,
  output logic [1:0]           s_bresp_o,
  output logic                 s_bvalid_o,
  input  logic                 s_bready_i,
  input  logic [AW-1:0]        s_araddr_i,
  input  logic                 s_arvalid_i,
  output logic                 s_arready_o,
  output logic [DW-1:0]        s_rdata_o,
  output logic [1:0]           s_rresp_o,
  output logic                 s_rvalid_o,
  input  logic                 s_rready_i,
  // downstream master side, port i occupies slice i of each flat vector
  output logic [NM*AW-1:0]     m_awaddr_o,
  output logic [NM-1:0]        m_awvalid_o,
  input  logic [NM-1:0]        m_awready_i,
  output logic [NM*DW-1:0]     m_wdata_o,
  output logic [NM*DW/8-1:0]   m_wstrb_o,
  output logic [NM-1:0]        m_wvalid_o,
  input  logic [NM-1:0]        m_wready_i,
  input  logic [2*NM-1:0]      m_bresp_i,
  input  logic [NM-1:0]        m_bvalid_i,
  output logic [NM-1:0]        m_bready_o,
  output logic [NM*AW-1:0]     m_araddr_o,
  output logic [NM-1:0]        m_arvalid_o,
  input  logic [NM-1:0]        m_arready_i,
  input  logic [NM*DW-1:0]     m_rdata_i,
  input  logic [2*NM-1:0]      m_rresp_i,
  input  logic [NM-1:0]        m_rvalid_i,
  output logic [NM-1:0]        m_rready_o
);

  localparam int unsigned SW = $clog2(NM);
  localparam int unsigned TW = $clog2(NM + 1);
  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam logic [TW-1:0] DecIdx = TW'(NM);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUT);

  // Index NM is the internal DECERR slot; without DECERR the field wraps (field < 2*NM).
  function automatic logic [TW-1:0] decode(input logic [SW-1:0] field);
    logic [TW-1:0] f;
    f = TW'(field);
    if (f >= DecIdx) return (DECERR_EN != 0) ? DecIdx : f - DecIdx;
    return f;
  endfunction

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt, input logic inc,
                                             input logic dec);
    if (inc && !dec) return cnt + 1'b1;
    if (dec && !inc && cnt != '0) return cnt - 1'b1;
    return cnt;
  endfunction

  logic [TW-1:0] wr_tgt_q, wr_tgt_d, rd_tgt_q, rd_tgt_d;
  logic [CW-1:0] aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d, ar_cnt_q, ar_cnt_d;

  logic          en;
  logic [TW-1:0] aw_sel, ar_sel;
  logic          aw_ok, ar_ok, w_open, wr_dec, rd_dec;
  logic          aw_down_rdy, w_down_rdy, b_down_vld, ar_down_rdy, r_down_vld;
  logic [1:0]    b_down_resp, r_down_resp;
  logic [DW-1:0] r_down_data;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign en = !areset;

  assign m_awaddr_o = {NM{s_awaddr_i}};
  assign m_wdata_o  = {NM{s_wdata_i}};
  assign m_wstrb_o  = {NM{s_wstrb_i}};
  assign m_araddr_o = {NM{s_araddr_i}};

  // Write path
  always_comb begin
    aw_sel      = decode(s_awaddr_i[SEL_LSB +: SW]);
    aw_ok       = ((aw_cnt_q == '0) || (aw_sel == wr_tgt_q)) && (aw_cnt_q < MaxCnt);
    w_open      = (w_cnt_q != '0);
    wr_dec      = (wr_tgt_q == DecIdx);
    m_awvalid_o = '0;
    m_wvalid_o  = '0;
    m_bready_o  = '0;
    aw_down_rdy = 1'b0;
    w_down_rdy  = 1'b0;
    b_down_vld  = 1'b0;
    b_down_resp = 2'b00;
    for (int i = 0; i < NM; i++) begin
      if (aw_sel == TW'(i)) begin
        m_awvalid_o[i] = en && s_awvalid_i && aw_ok;
        aw_down_rdy    = m_awready_i[i];
      end
      if (wr_tgt_q == TW'(i)) begin
        m_wvalid_o[i] = en && s_wvalid_i && w_open;
        m_bready_o[i] = en && s_bready_i;
        w_down_rdy    = m_wready_i[i];
        b_down_vld    = m_bvalid_i[i];
        b_down_resp   = m_bresp_i[2*i +: 2];
      end
    end
    s_awready_o = en && aw_ok && ((aw_sel == DecIdx) || aw_down_rdy);
    s_wready_o  = en && w_open && (wr_dec || w_down_rdy);
    // A DECERR write owes a B once its W has been swallowed.
    s_bvalid_o  = en && (wr_dec ? (aw_cnt_q > w_cnt_q) : b_down_vld);
    s_bresp_o   = wr_dec ? 2'b11 : b_down_resp;

    aw_hs    = s_awvalid_i && s_awready_o;
    w_hs     = s_wvalid_i && s_wready_o;
    b_hs     = s_bvalid_o && s_bready_i;
    wr_tgt_d = aw_hs ? aw_sel : wr_tgt_q;
    aw_cnt_d = cnt_next(aw_cnt_q, aw_hs, b_hs);
    w_cnt_d  = cnt_next(w_cnt_q, aw_hs, w_hs);
  end

  // Read path
  always_comb begin
    ar_sel      = decode(s_araddr_i[SEL_LSB +: SW]);
    ar_ok       = ((ar_cnt_q == '0) || (ar_sel == rd_tgt_q)) && (ar_cnt_q < MaxCnt);
    rd_dec      = (rd_tgt_q == DecIdx);
    m_arvalid_o = '0;
    m_rready_o  = '0;
    ar_down_rdy = 1'b0;
    r_down_vld  = 1'b0;
    r_down_resp = 2'b00;
    r_down_data = '0;
    for (int i = 0; i < NM; i++) begin
      if (ar_sel == TW'(i)) begin
        m_arvalid_o[i] = en && s_arvalid_i && ar_ok;
        ar_down_rdy    = m_arready_i[i];
      end
      if (rd_tgt_q == TW'(i)) begin
        m_rready_o[i] = en && s_rready_i;
        r_down_vld    = m_rvalid_i[i];
        r_down_resp   = m_rresp_i[2*i +: 2];
        r_down_data   = m_rdata_i[DW*i +: DW];
      end
    end
    s_arready_o = en && ar_ok && ((ar_sel == DecIdx) || ar_down_rdy);
    s_rvalid_o  = en && (rd_dec ? (ar_cnt_q != '0) : r_down_vld);
    s_rresp_o   = rd_dec ? 2'b11 : r_down_resp;
    s_rdata_o   = rd_dec ? '0 : r_down_data;

    ar_hs    = s_arvalid_i && s_arready_o;
    r_hs     = s_rvalid_o && s_rready_i;
    rd_tgt_d = ar_hs ? ar_sel : rd_tgt_q;
    ar_cnt_d = cnt_next(ar_cnt_q, ar_hs, r_hs);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_tgt_q <= '0;
      rd_tgt_q <= '0;
      aw_cnt_q <= '0;
      w_cnt_q  <= '0;
      ar_cnt_q <= '0;
    end else begin
      wr_tgt_q <= wr_tgt_d;
      rd_tgt_q <= rd_tgt_d;
      aw_cnt_q <= aw_cnt_d;
      w_cnt_q  <= w_cnt_d;
      ar_cnt_q <= ar_cnt_d;
    end
  end

  // A response with nothing outstanding means a downstream protocol violation.
  b_has_req_a: assert property (@(posedge aclk) disable iff (areset) b_hs |-> aw_cnt_q != '0);
  r_has_req_a: assert property (@(posedge aclk) disable iff (areset) r_hs |-> ar_cnt_q != '0);

endmodule
